// File: rtl/data_packer_pkg.sv
// Shared constants and width helper for the data_packer block.
package data_packer_pkg;

  localparam int DATA_W2_DEF = 5;
  localparam int PACK_N_DEF  = 4;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/data_packer_if.sv
// Word-stream input, packet valid/ready output and status bundle of data_packer.
interface data_packer_if
  import data_packer_pkg::*;
#(
  parameter int DATA_W2 = DATA_W2_DEF,
  parameter int PACK_N  = PACK_N_DEF
) ();

  localparam int CNT_W = cnt_width(PACK_N);
  localparam int PKT_W = PACK_N * DATA_W2;

  logic [DATA_W2-1:0] data_in;
  logic               data_en;
  logic               flush;
  logic               ovf_clr;
  logic [PKT_W-1:0]   pack_out;
  logic [CNT_W-1:0]   pack_len;
  logic               pack_valid;
  logic               pack_ready;
  logic               overflow;
  logic [CNT_W-1:0]   asm_cnt;

  modport slave (
    input  data_in, data_en, flush, ovf_clr, pack_ready,
    output pack_out, pack_len, pack_valid, overflow, asm_cnt
  );

  modport master (
    output data_in, data_en, flush, ovf_clr, pack_ready,
    input  pack_out, pack_len, pack_valid, overflow, asm_cnt
  );

endinterface

// File: rtl/data_packer_pack_hold_reg.sv
// Output holding register: loads a packet, keeps it stable until the consumer takes it.
module pack_hold_reg #(
  parameter int PKT_W = 20,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [PKT_W-1:0] load_data_i,
  input  logic [CNT_W-1:0] load_len_i,
  input  logic             ready_i,
  output logic [PKT_W-1:0] data_o,
  output logic [CNT_W-1:0] len_o,
  output logic             valid_o
);

  logic [PKT_W-1:0] data_q;
  logic [CNT_W-1:0] len_q;
  logic             valid_q;

  // Load has priority; a plain drain only drops valid, data/len keep their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= load_data_i;
      len_q   <= load_len_i;
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign data_o  = data_q;
  assign len_o   = len_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/data_packer.sv
// Packs PACK_N strobed words into one packet; drops and flags words when both stages are full.
module data_packer
  import data_packer_pkg::*;
#(
  parameter int DATA_W2 = DATA_W2_DEF,
  parameter int PACK_N  = PACK_N_DEF
) (
  input  logic          clk,
  input  logic          rst,
  data_packer_if.slave  bus
);

  localparam int CNT_W = cnt_width(PACK_N);
  localparam int PKT_W = PACK_N * DATA_W2;

  logic [PKT_W-1:0] asm_buf_q, asm_buf_d;
  logic [CNT_W-1:0] asm_cnt_q, asm_cnt_d;
  logic             asm_closed_q, asm_closed_d;
  logic             ovf_q, ovf_d;

  logic             pack_valid_s;
  logic             drain_s;
  logic             out_free_s;
  logic             xfer_s;
  logic             drop_s;

  // Handshake terms deciding whether the closed buffer moves to the output stage.
  always_comb begin
    drain_s    = pack_valid_s & bus.pack_ready;
    out_free_s = ~pack_valid_s | drain_s;
    xfer_s     = asm_closed_q & out_free_s;
  end

  // Assembly next state: transfer empties the buffer first, so a same-cycle word lands in slot 0.
  always_comb begin
    asm_buf_d    = xfer_s ? '0 : asm_buf_q;
    asm_cnt_d    = xfer_s ? '0 : asm_cnt_q;
    asm_closed_d = xfer_s ? 1'b0 : asm_closed_q;
    drop_s       = 1'b0;
    if (bus.data_en) begin
      if (asm_closed_d) begin
        drop_s = 1'b1;
      end else begin
        for (int i = 0; i < PACK_N; i++) begin
          if (CNT_W'(i) == asm_cnt_d) begin
            asm_buf_d[i*DATA_W2 +: DATA_W2] = bus.data_in;
          end else begin
            asm_buf_d[i*DATA_W2 +: DATA_W2] = asm_buf_d[i*DATA_W2 +: DATA_W2];
          end
        end
        asm_cnt_d    = asm_cnt_d + CNT_W'(1);
        asm_closed_d = (asm_cnt_d == CNT_W'(PACK_N));
      end
    end else begin
      drop_s = 1'b0;
    end
    if (bus.flush && (asm_cnt_d != '0) && !asm_closed_d) begin
      asm_closed_d = 1'b1;
    end else begin
      asm_closed_d = asm_closed_d;
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Assembly buffer and sticky overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_buf_q    <= '0;
      asm_cnt_q    <= '0;
      asm_closed_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      asm_buf_q    <= asm_buf_d;
      asm_cnt_q    <= asm_cnt_d;
      asm_closed_q <= asm_closed_d;
      ovf_q        <= ovf_d;
    end
  end

  pack_hold_reg #(
    .PKT_W (PKT_W),
    .CNT_W (CNT_W)
  ) u_hold (
    .clk         (clk),
    .rst         (rst),
    .load_i      (xfer_s),
    .load_data_i (asm_buf_q),
    .load_len_i  (asm_cnt_q),
    .ready_i     (bus.pack_ready),
    .data_o      (bus.pack_out),
    .len_o       (bus.pack_len),
    .valid_o     (pack_valid_s)
  );

  assign bus.pack_valid = pack_valid_s;
  assign bus.asm_cnt    = asm_cnt_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_data_packer.sv
// Directed bench for data_packer with a queue-based packet model checked every cycle.
module tb_data_packer;

  localparam int DW = 5;
  localparam int PN = 4;
  localparam int CW = 3;
  localparam int PW = DW * PN;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  data_packer_if #(.DATA_W2(DW), .PACK_N(PN)) bus ();

  data_packer #(.DATA_W2(DW), .PACK_N(PN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: words waiting to be packed and the packet offered to the consumer.
  logic [DW-1:0] m_asm[$];
  bit            m_closed;
  bit            m_valid;
  bit            m_ovf;
  logic [PW-1:0] m_out;
  logic [CW-1:0] m_len;

  function automatic logic [PW-1:0] pack_words(input logic [DW-1:0] q[$]);
    logic [PW-1:0] r;
    r = '0;
    foreach (q[i]) r = r | (PW'(q[i]) << (i * DW));
    return r;
  endfunction

  task automatic model_reset();
    m_asm.delete();
    m_closed = 1'b0;
    m_valid  = 1'b0;
    m_ovf    = 1'b0;
    m_out    = '0;
    m_len    = '0;
  endtask

  task automatic model_step();
    bit drain;
    bit dropped;
    drain   = m_valid && bus.pack_ready;
    dropped = 1'b0;
    if (m_closed && (!m_valid || drain)) begin
      m_out   = pack_words(m_asm);
      m_len   = CW'(m_asm.size());
      m_valid = 1'b1;
      m_asm.delete();
      m_closed = 1'b0;
    end else if (drain) begin
      m_valid = 1'b0;
    end
    if (bus.data_en) begin
      if (m_closed) begin
        dropped = 1'b1;
      end else begin
        m_asm.push_back(bus.data_in);
        if (m_asm.size() == PN) m_closed = 1'b1;
      end
    end
    if (bus.flush && !m_closed && m_asm.size() > 0) m_closed = 1'b1;
    if (dropped) m_ovf = 1'b1;
    else if (bus.ovf_clr) m_ovf = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Every cycle out of reset the DUT must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_pack_valid", 32'(bus.pack_valid), 32'(m_valid));
      chk("m_pack_out",   32'(bus.pack_out),   32'(m_out));
      chk("m_pack_len",   32'(bus.pack_len),   32'(m_len));
      chk("m_overflow",   32'(bus.overflow),   32'(m_ovf));
      chk("m_asm_cnt",    32'(bus.asm_cnt),    32'(m_asm.size()));
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic en, input logic [DW-1:0] d, input logic fl,
                       input logic clr, input logic rdy);
    bus.data_en    = en;
    bus.data_in    = d;
    bus.flush      = fl;
    bus.ovf_clr    = clr;
    bus.pack_ready = rdy;
    cycle();
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 5'h00, 1'b0, 1'b0, rdy);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pack_out"},   32'(bus.pack_out),   32'h0);
    chk({tag, "_pack_len"},   32'(bus.pack_len),   32'h0);
    chk({tag, "_pack_valid"}, 32'(bus.pack_valid), 32'h0);
    chk({tag, "_overflow"},   32'(bus.overflow),   32'h0);
    chk({tag, "_asm_cnt"},    32'(bus.asm_cnt),    32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.data_en = 1'b0; bus.data_in = '0; bus.flush = 1'b0;
    bus.ovf_clr = 1'b0; bus.pack_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // 1: full packet with ready high
    for (int w = 1; w <= 4; w++) drive(1'b1, 5'(w), 1'b0, 1'b0, 1'b1);
    chk("t1_not_yet_valid", 32'(bus.pack_valid), 32'h0);
    idle(1'b1);
    chk("t1_valid", 32'(bus.pack_valid), 32'h1);
    chk("t1_out",   32'(bus.pack_out),   32'h20C41);
    chk("t1_len",   32'(bus.pack_len),   32'h4);
    chk("t1_ovf",   32'(bus.overflow),   32'h0);
    idle(1'b1);
    chk("t1_one_cycle", 32'(bus.pack_valid), 32'h0);

    // 2: partial flush
    drive(1'b1, 5'h1F, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 5'h0A, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 5'h00, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("t2_out", 32'(bus.pack_out), 32'h0015F);
    chk("t2_len", 32'(bus.pack_len), 32'h2);
    chk("t2_cnt", 32'(bus.asm_cnt),  32'h0);
    idle(1'b1);
    drive(1'b0, 5'h00, 1'b1, 1'b0, 1'b1);
    chk("t2_empty_flush", 32'(bus.asm_cnt), 32'h0);

    // 3: flush on the same cycle as a word
    drive(1'b1, 5'h03, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 5'h05, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("t3_out", 32'(bus.pack_out), 32'h000A3);
    chk("t3_len", 32'(bus.pack_len), 32'h2);
    idle(1'b1);

    // 4: backpressure fills both stages, ninth word dropped
    for (int w = 1; w <= 8; w++) drive(1'b1, 5'(w), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5'h09, 1'b0, 1'b0, 1'b0);
    chk("t4_held_out", 32'(bus.pack_out),   32'h20C41);
    chk("t4_held_vld", 32'(bus.pack_valid), 32'h1);
    chk("t4_asm_full", 32'(bus.asm_cnt),    32'h4);
    chk("t4_ovf",      32'(bus.overflow),   32'h1);

    // 5: drop beats clear, clear alone wins otherwise
    drive(1'b1, 5'h0B, 1'b0, 1'b1, 1'b0);
    chk("t5_set_wins", 32'(bus.overflow), 32'h1);
    drive(1'b0, 5'h00, 1'b0, 1'b1, 1'b0);
    chk("t5_cleared", 32'(bus.overflow), 32'h0);
    drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b1);
    chk("t4_pkt2_out", 32'(bus.pack_out),   32'h41CC5);
    chk("t4_pkt2_vld", 32'(bus.pack_valid), 32'h1);
    idle(1'b1);
    chk("t4_drained", 32'(bus.pack_valid), 32'h0);

    // continuous stream at full rate
    for (int w = 0; w < 12; w++) drive(1'b1, 5'(w + 16), 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    chk("stream_no_drop", 32'(bus.overflow), 32'h0);
    repeat (2) idle(1'b1);

    // 6: async reset with a held packet and a partial buffer
    for (int w = 1; w <= 4; w++) drive(1'b1, 5'(w), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5'h09, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5'h0A, 1'b0, 1'b0, 1'b0);
    chk("t6_pre_vld", 32'(bus.pack_valid), 32'h1);
    chk("t6_pre_cnt", 32'(bus.asm_cnt),    32'h2);
    bus.data_en = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk_all_zero("t6_async");
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int w = 11; w <= 14; w++) drive(1'b1, 5'(w), 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    chk("t6_fresh_out", 32'(bus.pack_out), 32'h7358B);
    chk("t6_fresh_len", 32'(bus.pack_len), 32'h4);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
